// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: single-outstanding imem handshake, one-entry skid buffer, IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects into a sticky FAULT state.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] instr_p0;
  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;

  logic        take_redirect;
  logic        redirect_bad;
  logic [31:0] redirect_target;
  logic        resp_pending;
  logic        load_mem;
  logic        load_skid;
  logic        store_skid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
`else
  assign redirect_bad    = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // FAULT is terminal until reset, so redirects there are ignored
  assign take_redirect = redirect_valid && (state != S_FAULT);

  // A response is still owed to us after this edge: accepted now, or accepted earlier and not yet back
  assign resp_pending = ((state == S_FETCH) && imem_ready) ||
                        (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid);

  assign load_mem   = !take_redirect && (state == S_WAIT) && imem_rvalid && (!vld_p1 || !stall);
  assign store_skid = !take_redirect && (state == S_WAIT) && imem_rvalid && vld_p1 && stall;
  assign load_skid  = !take_redirect && (state == S_HOLD) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: if (imem_ready) state_n = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!vld_p1 || !stall) state_n = S_FETCH;
          else                   state_n = S_HOLD;
        end
      end
      S_HOLD:  if (!stall) state_n = S_FETCH;
      S_DRAIN: if (imem_rvalid) state_n = S_FETCH;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_FETCH;
    endcase
    if (take_redirect) begin
      if (redirect_bad)      state_n = S_FAULT;
      else if (resp_pending) state_n = S_DRAIN;
      else                   state_n = S_FETCH;
    end
  end

  // imem_req depends only on the state register (and reset), never on rvalid or stall
  always_comb begin
    imem_req = 1'b0;
    if ((state == S_FETCH) && !reset) imem_req = 1'b1;
  end

  // Stage p1: PC and IF/ID control
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      pc_p1  <= 32'h0000_0000;
    end else if (take_redirect) begin
      pc     <= redirect_target;
      vld_p1 <= 1'b0;
    end else begin
      if ((state == S_WAIT) && imem_rvalid) pc <= pc + 32'd4;
      if (load_mem) begin
        vld_p1 <= 1'b1;
        pc_p1  <= pc;
      end else if (load_skid) begin
        vld_p1 <= 1'b1;
        pc_p1  <= pc_p0;
      end else if (!stall) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p0/p1 data: skid buffer and instruction word, validity carried by state and vld_p1
  always_ff @(posedge clk) begin
    if (store_skid) begin
      instr_p0 <= imem_rdata;
      pc_p0    <= pc;
    end
    if (load_mem) begin
      instr_p1 <= imem_rdata;
    end else if (load_skid) begin
      instr_p1 <= instr_p0;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (take_redirect && redirect_bad) begin
      fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem_addr   = pc;
  assign if_valid    = vld_p1;
  assign if_instr    = vld_p1 ? instr_p1 : NOP_INSTR;
  assign if_pc       = pc_p1;
  assign if_pc_plus4 = pc_p1 + 32'd4;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the RV32I pipeline. Owns the program counter and issues word fetches to instruction memory over a request/response handshake. Registers each returned instruction with its PC into the IF/ID output register. That register feeds the instruction parser in decode. Also absorbs decode back-pressure (stall) and control-flow redirects from execute (branch/jump flush).

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when not valid (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address (word aligned)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; never in the same cycle as its accepting imem_ready
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept; hold if_* outputs
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch target
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  32  instruction to the parser
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4 (mod 2^32)
- fault  out  1  misaligned redirect trap (see Configuration)

## Operation
- At most one outstanding memory request. One-entry skid buffer between memory and the IF/ID register.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready, go to WAIT.
  - imem_req is held high and imem_addr stable until imem_ready.
- State WAIT: on imem_rvalid, pc <= pc+4 (wraps at 2^32).
  - If if_valid=0 or stall=0: load if_instr/if_pc, set if_valid=1, go to FETCH.
  - Otherwise: store the word in the buffer and go to HOLD.
- State HOLD: imem_req=0. When stall=0, move the buffer into the IF/ID register and go to FETCH.
- State DRAIN: an in-flight response must be discarded. imem_req=0. On imem_rvalid, drop the data and go to FETCH.
- Consumption: the IF/ID register empties (if_valid<=0) when stall=0, unless new data loads in the same cycle.
- Redirect has highest priority, in any state and regardless of stall:
  - pc <= redirect_pc, if_valid <= 0, buffer cleared.
  - Next state is DRAIN if a request was accepted and its response has not arrived (including imem_ready this cycle); otherwise FETCH.
  - Redirect in the same cycle as imem_rvalid: data dropped, pc takes redirect_pc, next state FETCH.
  - An in-flight request is never cancelled; it is drained.
- When if_valid=0, if_instr = NOP_INSTR.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0 during the reset cycle, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=4, fault=0, buffer empty.
- First imem_req=1 in the first cycle after reset deasserts.
- imem_rvalid at cycle N gives if_valid=1 with that word at N+1.
- Peak throughput, with zero-wait memory (ready in request cycle, rvalid the next cycle) and no stall: one instruction per 2 cycles.
- imem_req is registered from state. There is no combinational path from imem_rvalid or stall to imem_req.
- Reset asserted mid-operation wins over everything. Outstanding responses arriving after reset are ignored, because state is FETCH.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fault=1 (sticky until reset) and enters state FAULT.
  - FAULT: imem_req=0, if_valid=0. An outstanding response is drained and discarded. Stays in FAULT until reset.
- Not defined: redirect_pc[1:0] forced to 0 on load, and fault tied to 0.

## Test plan
- Reset sequence: hold reset 3 cycles with RESET_PC=32'h100 -> all outputs at reset values. The cycle after release: imem_req=1, imem_addr=32'h100.
- Straight-line fetch, zero-wait memory returning 32'h00500093, 32'h00A00113 -> if_pc=0x100 then 0x104; correct if_instr; if_pc_plus4=0x104/0x108; one instruction per 2 cycles.
- Stall raised during WAIT -> word held in HOLD, imem_req=0, if_* unchanged. After stall drops, the buffered word appears next cycle and the following fetch is at pc+4.
- Redirect to 0x200 while WAIT (response pending) -> if_valid=0 next cycle. Stale rvalid data never appears on if_instr. Next request is imem_addr=0x200.
- Redirect to 0x300 in the same cycle as imem_rvalid, with stall=1 -> data dropped, if_valid=0, next imem_addr=0x300.
- With FETCH_ALIGN_CHECK_EN: redirect to 0x202 -> fault=1 next cycle, imem_req stays 0 until reset. Without the macro: next imem_addr=0x200, fault=0.
